gate_exhaustive_checker: RTL and testbench

//   Self-checking stimulus/response stage for any 2-input combinational gate.
//   On start, drives the gate inputs a,b through 00,01,10,11 and holds each

---
 rtl/gate_exhaustive_checker.sv | 135 +++++++++++++
 tb/tb_gate_exhaustive_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_exhaustive_checker.sv
// Stimulus/response checker for a 2-input combinational gate: it walks {a,b}
// through 00..11, samples c at the end of each hold and tallies mismatches.
module gate_exhaustive_checker #(
    parameter int         HOLD_CYCLES = 100,
    parameter logic [3:0] TRUTH       = 4'b0111,
    parameter int         ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [1:0]       first_err_vec,
    output logic [1:0]       fsm_state
);

    localparam int               CNT_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Handshake: start is a single-cycle request, accepted only while busy=0
    // (IDLE or DONE); requests seen during a run are dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       vec, vec_n;
    logic             a_n, b_n, busy_n, done_n, pass_n;
    logic [ERR_W-1:0] err_n, err_inc;
    logic             fev_n;
    logic [1:0]       fvec_n;
    logic             mismatch;

    assign fsm_state = state;
    assign err_inc   = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            vec             <= '0;
            a               <= 1'b0;
            b               <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            vec             <= vec_n;
            a               <= a_n;
            b               <= b_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
            err_count       <= err_n;
            first_err_valid <= fev_n;
            first_err_vec   <= fvec_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        vec_n    = vec;
        a_n      = a;
        b_n      = b;
        busy_n   = busy;
        done_n   = done;
        pass_n   = pass;
        err_n    = err_count;
        fev_n    = first_err_valid;
        fvec_n   = first_err_vec;
        mismatch = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    vec_n   = 2'd0;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    fev_n   = 1'b0;
                    fvec_n  = 2'd0;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    // a,b have been stable for the whole hold, so c is settled here
                    mismatch = (c != TRUTH[vec]);
                    if (mismatch) begin
                        err_n = err_inc;
                        if (!first_err_valid) begin
                            fev_n  = 1'b1;
                            fvec_n = vec;
                        end
                    end
                    cnt_n = '0;
                    if (vec == 2'd3) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        pass_n  = (err_n == '0);
                    end else begin
                        vec_n      = vec + 2'd1;
                        {a_n, b_n} = vec + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for gate_exhaustive_checker: three configurations driven by directed
// runs, checked every cycle against an elapsed-time model plus literal values.
module tb_gate_exhaustive_checker;

    logic       clk;
    logic       rst_n;
    logic       start_s [3];
    logic       c_s     [3];
    logic       a_s     [3];
    logic       b_s     [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic       fev_s   [3];
    logic [1:0] fvec_s  [3];
    logic [1:0] st_s    [3];
    logic [7:0] err_s   [3];
    logic [7:0] err0, err1;
    logic [0:0] err2;
    int         mode    [3];

    int         n_checks = 0;
    int         n_fail   = 0;

    bit         m_phase  [3];
    int         m_t      [3];
    int         m_mode   [3];

    // gate under test: 0 NAND, 1 tied high, 2 tied low, 3 AND
    function automatic logic gate_fn(input int m, input logic x, input logic y);
        case (m)
            0:       return ~(x & y);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return x & y;
        endcase
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 100 : (i == 1) ? 1 : 3;
    endfunction

    function automatic logic [3:0] truth_of(input int i);
        return (i == 1) ? 4'b1000 : 4'b0111;
    endfunction

    function automatic int errw_of(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    assign c_s[0] = gate_fn(mode[0], a_s[0], b_s[0]);
    assign c_s[1] = gate_fn(mode[1], a_s[1], b_s[1]);
    assign c_s[2] = gate_fn(mode[2], a_s[2], b_s[2]);
    assign err_s[0] = err0;
    assign err_s[1] = err1;
    assign err_s[2] = {7'b0, err2};

    gate_exhaustive_checker #(.HOLD_CYCLES(100), .TRUTH(4'b0111), .ERR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .c(c_s[0]), .a(a_s[0]), .b(b_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err0),
        .first_err_valid(fev_s[0]), .first_err_vec(fvec_s[0]), .fsm_state(st_s[0])
    );
    gate_exhaustive_checker #(.HOLD_CYCLES(1), .TRUTH(4'b1000), .ERR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .c(c_s[1]), .a(a_s[1]), .b(b_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err1),
        .first_err_valid(fev_s[1]), .first_err_vec(fvec_s[1]), .fsm_state(st_s[1])
    );
    gate_exhaustive_checker #(.HOLD_CYCLES(3), .TRUTH(4'b0111), .ERR_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .c(c_s[2]), .a(a_s[2]), .b(b_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err2),
        .first_err_valid(fev_s[2]), .first_err_vec(fvec_s[2]), .fsm_state(st_s[2])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: whether a run was ever accepted since reset, and how many
    // clock edges have elapsed since the accepting edge.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_phase[i] <= 1'b0;
                m_t[i]     <= 0;
            end else if (start_s[i] && !(m_phase[i] && m_t[i] < 4 * hold_of(i))) begin
                m_phase[i] <= 1'b1;
                m_t[i]     <= 0;
                m_mode[i]  <= mode[i];
            end else if (m_phase[i] && m_t[i] < 4 * hold_of(i)) begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    // {a,b,busy,done,pass,first_err_valid,first_err_vec[1:0],err_count[7:0]}
    function automatic logic [15:0] model_out(input int i);
        int         h;
        int         ew;
        int         vecs_done;
        int         cur;
        int         mism;
        int         first;
        int         errc;
        int         sat;
        logic [3:0] tt;
        logic       pa, pb, pbusy, pdone, ppass, g;
        logic [1:0] vv;
        logic [1:0] fv;
        logic [7:0] e8;
        h     = hold_of(i);
        ew    = errw_of(i);
        tt    = truth_of(i);
        mism  = 0;
        first = -1;
        if (!m_phase[i]) return 16'h0000;
        if (m_t[i] < 4 * h) begin
            vecs_done = m_t[i] / h;
            cur       = vecs_done;
            pa        = cur[1];
            pb        = cur[0];
            pbusy     = 1'b1;
            pdone     = 1'b0;
        end else begin
            vecs_done = 4;
            pa        = 1'b0;
            pb        = 1'b0;
            pbusy     = 1'b0;
            pdone     = 1'b1;
        end
        for (int v = 0; v < vecs_done; v++) begin
            vv = v[1:0];
            g  = gate_fn(m_mode[i], vv[1], vv[0]);
            if (g != tt[v]) begin
                mism++;
                if (first < 0) first = v;
            end
        end
        sat   = (1 << ew) - 1;
        errc  = (mism > sat) ? sat : mism;
        e8    = errc[7:0];
        ppass = pdone && (errc == 0);
        fv    = (first >= 0) ? first[1:0] : 2'b00;
        return {pa, pb, pbusy, pdone, ppass, (first >= 0), fv, e8};
    endfunction

    function automatic logic [15:0] dut_out(input int i);
        return {a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i], fev_s[i], fvec_s[i], err_s[i]};
    endfunction

    // scoreboard: every DUT compared with the model on every falling edge
    always @(negedge clk) begin
        logic [15:0] got;
        logic [15:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            got   = dut_out(i);
            exp_v = model_out(i);
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model dut%0d t=%0t got=%h expected=%h", i, $time, got, exp_v);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp_v);
        n_checks++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
        end
    endtask

    // driver: call at a falling edge; pulses start and counts cycles to done
    task automatic run_dut(input int i, input int repulse_at, output int cycles);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        check($sformatf("dut%0d_accept_busy", i), int'(busy_s[i]), 1);
        check($sformatf("dut%0d_accept_done", i), int'(done_s[i]), 0);
        check($sformatf("dut%0d_accept_err", i), int'(err_s[i]), 0);
        cycles = 0;
        while (!done_s[i] && cycles < 2000) begin
            if (cycles == repulse_at) start_s[i] = 1'b1;
            @(negedge clk);
            start_s[i] = 1'b0;
            cycles++;
        end
        check($sformatf("dut%0d_done_reached", i), int'(done_s[i]), 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            mode[i]    = 0;
        end
        #1 rst_n = 1'b0;
        #2 check("reset_outputs", int'(dut_out(0)), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // T1: good NAND
        mode[0] = 0;
        run_dut(0, -1, cyc);
        check("t1_cycles", cyc, 400);
        check("t1_err", int'(err_s[0]), 0);
        check("t1_pass", int'(pass_s[0]), 1);
        check("t1_fev", int'(fev_s[0]), 0);

        // T2: c stuck high
        mode[0] = 1;
        run_dut(0, -1, cyc);
        check("t2_err", int'(err_s[0]), 1);
        check("t2_fvec", int'(fvec_s[0]), 3);
        check("t2_pass", int'(pass_s[0]), 0);

        // T3: c stuck low
        mode[0] = 2;
        run_dut(0, -1, cyc);
        check("t3_err", int'(err_s[0]), 3);
        check("t3_fvec", int'(fvec_s[0]), 0);
        check("t3_fev", int'(fev_s[0]), 1);

        // T5: restart from done, with a stray start mid-run
        mode[0] = 0;
        run_dut(0, 150, cyc);
        check("t5_cycles", cyc, 400);
        check("t5_pass", int'(pass_s[0]), 1);

        // T4: reset while vector 2 is driven
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (a_s[0] && !b_s[0]) break;
            @(negedge clk);
        end
        check("t4_reached_vec2", int'({a_s[0], b_s[0]}), 2);
        repeat (10) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("t4_reset_outputs", int'(dut_out(0)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dut(0, -1, cyc);
        check("t4_cycles", cyc, 400);
        check("t4_pass", int'(pass_s[0]), 1);

        // T6: single-cycle hold with AND, and a 1-bit saturating counter
        mode[1] = 3;
        run_dut(1, -1, cyc);
        check("t6_cycles", cyc, 4);
        check("t6_pass", int'(pass_s[1]), 1);
        mode[2] = 2;
        run_dut(2, -1, cyc);
        check("t6_sat_cycles", cyc, 12);
        check("t6_sat_err", int'(err_s[2]), 1);
        check("t6_sat_fvec", int'(fvec_s[2]), 0);
        check("t6_sat_pass", int'(pass_s[2]), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
